alu_share_ctrl: RTL

- Time-multiplexes one combinational 32-bit ALU (ops AND/OR/ADD/SUB/SLT) between two requesters, e.g. the integer issue path and the address-generation path.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers operands, sequences one ALU evaluation per transaction and holds the result until the owning requester accepts it.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_share_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: ALU op codes, the
// supported-op check and the controller FSM state type.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] OP_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] OP_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] OP_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] OP_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  // True when the shared ALU implements the given control code.
  function automatic logic op_supported(input logic [CTRL_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win last
// time is granted; a lone requester always wins. No grant when disabled.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // Grant is one-hot or zero.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_grant ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-multiplexes one external combinational ALU between two requesters.
// One transaction at a time: accept (IDLE), evaluate for one cycle (EXEC),
// then hold the result until the owning requester takes it (RESP).
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTRLW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [CTRLW-1:0] req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [CTRLW-1:0] req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTRLW-1:0] alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CTRLW-1:0] op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [1:0]       gnt;
  logic             arb_en;

  // Gating with rst_n keeps req_ready low while reset is held, even though
  // the state register already reads IDLE.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt)
  );

  // Only the winner sees ready, so a handshake is simply any grant.
  assign req_ready = gnt;

  // Next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          grant_d = gnt[1];
          a_d     = gnt[1] ? req_a1  : req_a0;
          b_d     = gnt[1] ? req_b1  : req_b0;
          op_d    = gnt[1] ? req_op1 : req_op0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Unsupported codes still pass the ALU's output through, flagged.
        result_d = alu_result;
        zero_d   = alu_zero;
        err_d    = ~op_supported(op_q);
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0
  // wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
    end
  end

  // Outputs: ALU inputs hold the latched operands outside EXEC as well.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == RESP) begin
      rsp_valid = grant_q ? 2'b10 : 2'b01;
    end
    rsp_result  = result_q;
    rsp_zero    = zero_q;
    rsp_err     = err_q;
    alu_a       = a_q;
    alu_b       = b_q;
    alu_control = op_q;
  end

endmodule
